uart_rx_fsm: RTL and testbench



---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_sync.sv | 27 ++
 rtl/uart_rx_fsm.sv | 133 +++++++++++++
 tb/tb_uart_rx_fsm.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receiver and the transmitter.
// Frame geometry and receiver state encoding live here.
package uart_pkg;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
// Resets to the idle level so a reset never looks like a start bit.
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= UART_IDLE_LEVEL;
            sync_q <= UART_IDLE_LEVEL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx_fsm.sv
// 8N1 UART receiver: midpoint sampling from a clock-count bit period,
// one-cycle valid strobe per good byte and a framing-error strobe.
module uart_rx_fsm
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_serial,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

    logic rx_s;

    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx_serial),
        .q     (rx_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rx_s != UART_IDLE_LEVEL) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == HALF_CNT) begin
                    cnt_d = '0;
                    // A start bit that is gone by mid-bit was a glitch.
                    if (rx_s != UART_IDLE_LEVEL) begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    if (rx_s == UART_IDLE_LEVEL) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            BREAK: begin
                // Wait out a held-low line so it is not mistaken for a start.
                if (rx_s == UART_IDLE_LEVEL) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rx_data      = data_q;
    assign rx_valid     = valid_q;
    assign rx_frame_err = ferr_q;
    assign rx_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Scoreboard bench for uart_rx_fsm: two instances (16 and 11 clocks/bit)
// fed by a behavioural 8N1 transmitter; a monitor checks every pulse.
module tb_uart_rx_fsm;

    localparam int CLK_T = 100;
    localparam int BIT0  = 16 * CLK_T;
    localparam int BIT1  = 11 * CLK_T;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ser0 = 1'b1;
    logic       ser1 = 1'b1;
    logic [7:0] d0, d1;
    logic       v0, v1, fe0, fe1, b0, b1;

    int         checks = 0;
    int         failures = 0;
    ev_t        q0[$];
    ev_t        q1[$];
    logic [7:0] last_good[2];
    longint     vt0[$];

    always #(CLK_T / 2) clk = ~clk;

    uart_rx_fsm #(.CLKS_PER_BIT(16)) u_dut0 (
        .clk          (clk),
        .reset        (reset),
        .rx_serial    (ser0),
        .rx_data      (d0),
        .rx_valid     (v0),
        .rx_frame_err (fe0),
        .rx_busy      (b0)
    );

    uart_rx_fsm #(.CLKS_PER_BIT(11)) u_dut1 (
        .clk          (clk),
        .reset        (reset),
        .rx_serial    (ser1),
        .rx_data      (d1),
        .rx_valid     (v1),
        .rx_frame_err (fe1),
        .rx_busy      (b1)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_data0"}, d0, 0);
        chk({tag, "_valid0"}, v0, 0);
        chk({tag, "_ferr0"}, fe0, 0);
        chk({tag, "_busy0"}, b0, 0);
        chk({tag, "_data1"}, d1, 0);
        chk({tag, "_busy1"}, b1, 0);
    endtask

    task automatic push_ev(input int i, input ev_t e);
        if (i == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic expect_ok(input int i, input logic [7:0] b);
        ev_t e;
        e.kind = 1;
        e.data = b;
        last_good[i] = b;
        push_ev(i, e);
    endtask

    task automatic expect_ferr(input int i);
        ev_t e;
        e.kind = 2;
        e.data = last_good[i];
        push_ev(i, e);
    endtask

    task automatic set_line(input int i, input logic lv);
        if (i == 0) ser0 = lv;
        else ser1 = lv;
    endtask

    task automatic send_frame(input int i, input logic [7:0] b,
                              input logic stop, input int bt);
        set_line(i, 1'b0);
        #(bt);
        for (int k = 0; k < 8; k++) begin
            set_line(i, b[k]);
            #(bt);
        end
        set_line(i, stop);
        #(bt);
    endtask

    task automatic score(input int i, input logic v, input logic fe,
                         input logic [7:0] d);
        ev_t e;
        int  empty;
        chk($sformatf("pulse_exclusive_inst%0d", i), int'(v && fe), 0);
        empty = (i == 0) ? int'(q0.size() == 0) : int'(q1.size() == 0);
        if (empty != 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pulse_inst%0d: valid=%0b ferr=%0b data=%02h, none expected",
                     i, v, fe, d);
            return;
        end
        if (i == 0) e = q0.pop_front();
        else e = q1.pop_front();
        chk($sformatf("kind_inst%0d", i), v ? 1 : 2, e.kind);
        chk($sformatf("data_inst%0d", i), d, e.data);
        if (i == 0 && v) vt0.push_back(longint'($time));
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (v0 || fe0) score(0, v0, fe0, d0);
            if (v1 || fe1) score(1, v1, fe1, d1);
        end
    end

    initial begin
        #(20_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         base;
        longint     diff;
        int         n;
        int         bt;
        logic [7:0] rb;

        last_good[0] = 8'h00;
        last_good[1] = 8'h00;
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset_held");
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("after_release");

        // Single byte with busy-window checks.
        expect_ok(0, 8'hA5);
        @(negedge clk);
        fork
            send_frame(0, 8'hA5, 1'b1, BIT0);
            begin : busy_watch
                int cyc;
                int bad;
                cyc = 0;
                bad = 0;
                repeat (2) @(posedge clk);
                #1 chk("busy_clk2", b0, 0);
                @(posedge clk);
                #1 chk("busy_clk3", b0, 1);
                while (!v0 && cyc < 200) begin
                    if (!b0) bad++;
                    @(posedge clk);
                    #1;
                    cyc++;
                end
                chk("busy_held_until_valid", bad, 0);
                chk("valid_seen", int'(v0), 1);
            end
        join
        #(2 * BIT0);

        // Back-to-back frames, then one after a single idle bit.
        base = vt0.size();
        expect_ok(0, 8'h00);
        expect_ok(0, 8'hFF);
        expect_ok(0, 8'h5A);
        @(negedge clk);
        send_frame(0, 8'h00, 1'b1, BIT0);
        send_frame(0, 8'hFF, 1'b1, BIT0);
        #(BIT0);
        send_frame(0, 8'h5A, 1'b1, BIT0);
        #(2 * BIT0);
        chk("b2b_count", vt0.size() - base, 3);
        diff = (vt0.size() >= base + 2) ? vt0[base+1] - vt0[base] : 0;
        chk("b2b_spacing_ok", int'(diff >= 10 * BIT0 - CLK_T &&
                                   diff <= 10 * BIT0 + CLK_T), 1);

        // Short low glitch must be rejected.
        @(negedge clk);
        ser0 = 1'b0;
        repeat (5) @(negedge clk);
        chk("glitch_busy_seen", b0, 1);
        ser0 = 1'b1;
        n = 0;
        while (b0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("glitch_busy_clear", b0, 0);
        #(2 * BIT0);

        // Framing error followed by a held-low break.
        expect_ferr(0);
        @(negedge clk);
        send_frame(0, 8'h3C, 1'b0, BIT0);
        #(3 * BIT0);
        chk("break_busy", b0, 1);
        chk("break_data_kept", d0, 8'h5A);
        ser0 = 1'b1;
        #(2 * BIT0);
        chk("break_released", b0, 0);
        expect_ok(0, 8'h81);
        send_frame(0, 8'h81, 1'b1, BIT0);
        #(2 * BIT0);

        // Reset asserted during data bit 4.
        @(negedge clk);
        fork
            send_frame(0, 8'hC3, 1'b1, BIT0);
            begin
                #(5 * BIT0 + BIT0 / 2);
                reset = 1'b1;
                #1;
                chk("midreset_data", d0, 0);
                chk("midreset_valid", v0, 0);
                chk("midreset_ferr", fe0, 0);
                chk("midreset_busy", b0, 0);
            end
        join
        reset = 1'b0;
        last_good[0] = 8'h00;
        last_good[1] = 8'h00;
        #(BIT0);
        expect_ok(0, 8'h42);
        @(negedge clk);
        send_frame(0, 8'h42, 1'b1, BIT0);
        #(2 * BIT0);

        // Random bytes with +/-4% transmitter skew at 11 clocks per bit.
        for (int k = 0; k < 256; k++) begin
            rb = 8'($urandom);
            bt = BIT1 * (960 + int'($urandom_range(0, 80))) / 1000;
            expect_ok(1, rb);
            send_frame(1, rb, 1'b1, bt);
            #($urandom_range(0, 300));
        end
        #(3 * BIT1);

        chk("queue0_drained", q0.size(), 0);
        chk("queue1_drained", q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
